// File: rtl/param_sync_fifo.sv
// param_sync_fifo: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty margins and registered handshake pulses.
// Build option: define FIFO_FWFT_EN for first-word fall-through read data;
// leave it undefined for registered read data.
// Parameter constraints: FIFO_WIDTH >= 1, FIFO_DEPTH >= 2,
// 1 <= AF_MARGIN < FIFO_DEPTH, 1 <= AE_MARGIN < FIFO_DEPTH.
module param_sync_fifo #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AF_MARGIN  = 1,
    parameter int unsigned AE_MARGIN  = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [FIFO_WIDTH-1:0]             data_in,
    input  logic                              wr_en,
    input  logic                              rd_en,
    output logic [FIFO_WIDTH-1:0]             data_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              full,
    output logic                              empty,
    output logic                              almostfull,
    output logic                              almostempty,
    output logic                              wr_ack,
    output logic                              overflow,
    output logic                              underflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(FIFO_DEPTH - AF_MARGIN);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_MARGIN);

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [PTR_W-1:0]      w_wr_ptr_nxt;
    logic [PTR_W-1:0]      w_rd_ptr_nxt;

    // Status flags, acceptance and explicitly wrapping pointer increments
    always_comb begin
        w_full       = (r_count == CNT_FULL);
        w_empty      = (r_count == '0);
        w_wr_acc     = wr_en && !w_full;
        w_rd_acc     = rd_en && !w_empty;
        w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
        w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
    end

    // Storage write; contents survive reset, but nothing is written while in reset
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy and one-cycle handshake pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            unique case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_wr_ack    <= w_wr_acc;
            r_overflow  <= wr_en && w_full;
            r_underflow <= rd_en && w_empty;
        end
    end

`ifdef FIFO_FWFT_EN
    // Oldest word is presented directly from storage; meaningless while empty
    always_comb begin
        data_out = r_mem[r_rd_ptr];
    end
`else
    logic [FIFO_WIDTH-1:0] r_data_out;

    // Registered read data: loads only on an accepted read, holds otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
        end else if (w_rd_acc) begin
            r_data_out <= r_mem[r_rd_ptr];
        end
    end

    // Drive the registered read data out
    always_comb begin
        data_out = r_data_out;
    end
`endif

    // Outputs are all derived from registered state
    always_comb begin
        count       = r_count;
        full        = w_full;
        empty       = w_empty;
        almostfull  = (r_count >= CNT_AF) && !w_full;
        almostempty = (r_count <= CNT_AE) && !w_empty;
        wr_ack      = r_wr_ack;
        overflow    = r_overflow;
        underflow   = r_underflow;
    end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: two instances (depth 8 margins 1/1, depth 5 margins 2/2)
// checked every cycle against queue-based reference models.
module tb_param_sync_fifo;

    localparam int DA  = 8;
    localparam int AFA = 1;
    localparam int AEA = 1;
    localparam int DB  = 5;
    localparam int AFB = 2;
    localparam int AEB = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [15:0] data_in_a = '0, data_out_a;
    logic        wr_en_a = 1'b0, rd_en_a = 1'b0;
    logic [3:0]  count_a;
    logic        full_a, empty_a, af_a, ae_a, ack_a, ovf_a, udf_a;

    logic [15:0] data_in_b = '0, data_out_b;
    logic        wr_en_b = 1'b0, rd_en_b = 1'b0;
    logic [2:0]  count_b;
    logic        full_b, empty_b, af_b, ae_b, ack_b, ovf_b, udf_b;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    logic [15:0] exp_dout_a = '0, exp_dout_b = '0;
    logic        exp_ack_a = 0, exp_ovf_a = 0, exp_udf_a = 0;
    logic        exp_ack_b = 0, exp_ovf_b = 0, exp_udf_b = 0;

    param_sync_fifo #(
        .FIFO_WIDTH(16), .FIFO_DEPTH(DA), .AF_MARGIN(AFA), .AE_MARGIN(AEA)
    ) u_dut_a (
        .clk(clk), .rst(rst), .data_in(data_in_a), .wr_en(wr_en_a), .rd_en(rd_en_a),
        .data_out(data_out_a), .count(count_a), .full(full_a), .empty(empty_a),
        .almostfull(af_a), .almostempty(ae_a), .wr_ack(ack_a), .overflow(ovf_a),
        .underflow(udf_a)
    );

    param_sync_fifo #(
        .FIFO_WIDTH(16), .FIFO_DEPTH(DB), .AF_MARGIN(AFB), .AE_MARGIN(AEB)
    ) u_dut_b (
        .clk(clk), .rst(rst), .data_in(data_in_b), .wr_en(wr_en_b), .rd_en(rd_en_b),
        .data_out(data_out_b), .count(count_b), .full(full_b), .empty(empty_b),
        .almostfull(af_b), .almostempty(ae_b), .wr_ack(ack_b), .overflow(ovf_b),
        .underflow(udf_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sa, sb;
        sa = q_a.size();
        sb = q_b.size();
        chk("a_count", 32'(count_a), 32'(sa));
        chk("a_full", 32'(full_a), 32'(sa == DA));
        chk("a_empty", 32'(empty_a), 32'(sa == 0));
        chk("a_almostfull", 32'(af_a), 32'(sa >= DA - AFA && sa != DA));
        chk("a_almostempty", 32'(ae_a), 32'(sa <= AEA && sa != 0));
        chk("a_wr_ack", 32'(ack_a), 32'(exp_ack_a));
        chk("a_overflow", 32'(ovf_a), 32'(exp_ovf_a));
        chk("a_underflow", 32'(udf_a), 32'(exp_udf_a));
        chk("b_count", 32'(count_b), 32'(sb));
        chk("b_full", 32'(full_b), 32'(sb == DB));
        chk("b_empty", 32'(empty_b), 32'(sb == 0));
        chk("b_almostfull", 32'(af_b), 32'(sb >= DB - AFB && sb != DB));
        chk("b_almostempty", 32'(ae_b), 32'(sb <= AEB && sb != 0));
        chk("b_wr_ack", 32'(ack_b), 32'(exp_ack_b));
        chk("b_overflow", 32'(ovf_b), 32'(exp_ovf_b));
        chk("b_underflow", 32'(udf_b), 32'(exp_udf_b));
`ifdef FIFO_FWFT_EN
        if (sa > 0) chk("a_data_out", 32'(data_out_a), 32'(q_a[0]));
        if (sb > 0) chk("b_data_out", 32'(data_out_b), 32'(q_b[0]));
`else
        chk("a_data_out", 32'(data_out_a), 32'(exp_dout_a));
        chk("b_data_out", 32'(data_out_b), 32'(exp_dout_b));
`endif
    endtask

    // One clock edge for both FIFOs with the given requests, then model update and check
    task automatic step(input logic wa, input logic ra, input logic [15:0] da,
                        input logic wb, input logic rb, input logic [15:0] db);
        bit fa, ea, fb, eb;
        rst = 1'b0;
        wr_en_a = wa; rd_en_a = ra; data_in_a = da;
        wr_en_b = wb; rd_en_b = rb; data_in_b = db;
        @(posedge clk);
        fa = (q_a.size() == DA); ea = (q_a.size() == 0);
        fb = (q_b.size() == DB); eb = (q_b.size() == 0);
        exp_ack_a = wa && !fa; exp_ovf_a = wa && fa; exp_udf_a = ra && ea;
        exp_ack_b = wb && !fb; exp_ovf_b = wb && fb; exp_udf_b = rb && eb;
        if (ra && !ea) exp_dout_a = q_a.pop_front();
        if (wa && !fa) q_a.push_back(da);
        if (rb && !eb) exp_dout_b = q_b.pop_front();
        if (wb && !fb) q_b.push_back(db);
        #1;
        check_all();
    endtask

    // Reset both FIFOs while presenting a write that must be ignored
    task automatic do_reset(input logic [15:0] d);
        rst = 1'b1;
        wr_en_a = 1'b1; rd_en_a = 1'b1; data_in_a = d;
        wr_en_b = 1'b1; rd_en_b = 1'b1; data_in_b = d;
        @(posedge clk);
        q_a.delete(); q_b.delete();
        exp_dout_a = '0; exp_dout_b = '0;
        exp_ack_a = 0; exp_ovf_a = 0; exp_udf_a = 0;
        exp_ack_b = 0; exp_ovf_b = 0; exp_udf_b = 0;
        #1;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        // Reset, then idle
        do_reset(16'h5555);
        step(0, 0, 16'h0, 0, 0, 16'h0);

        // A: fill 1..8, then overflow with 0xDEAD
        for (int i = 1; i <= 8; i++) step(1, 0, 16'(i), 0, 0, 16'h0);
        step(1, 0, 16'hDEAD, 0, 0, 16'h0);
        // A: drain 8 in order, 9th read underflows and data holds
        for (int i = 0; i < 9; i++) step(0, 1, 16'h0, 0, 0, 16'h0);

        // A: full + simultaneous write/read
        for (int i = 0; i < 8; i++) step(1, 0, 16'($urandom), 0, 0, 16'h0);
        step(1, 1, 16'hBBBB, 0, 0, 16'h0);
        while (q_a.size() > 0) step(0, 1, 16'h0, 0, 0, 16'h0);
        // A: empty + simultaneous write/read, then read back 0x00AA
        step(1, 1, 16'h00AA, 0, 0, 16'h0);
        step(0, 1, 16'h0, 0, 0, 16'h0);

        // B: prefill 3, then 12 write/read pairs to wrap depth-5 pointers
        for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 1, 0, 16'(16'h100 + i));
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 16'h0, 1, 0, 16'($urandom));
            step(0, 0, 16'h0, 0, 1, 16'h0);
        end

        // Mid-stream reset with write asserted
        for (int i = 0; i < 3; i++) step(1, 0, 16'(16'h300 + i), 1, 0, 16'(16'h400 + i));
        do_reset(16'hBEEF);
        step(0, 0, 16'h0, 0, 0, 16'h0);

        // Single write visible at the output in fall-through builds
        step(1, 0, 16'h1234, 1, 0, 16'h1234);
        step(0, 0, 16'h0, 0, 0, 16'h0);
        step(0, 1, 16'h0, 0, 1, 16'h0);

        // Random traffic: write-heavy phase then read-heavy phase
        for (int i = 0; i < 600; i++) begin
            int pw;
            pw = (i % 200 < 100) ? 70 : 30;
            step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < 100 - pw, 16'($urandom),
                 $urandom_range(0, 99) < pw, $urandom_range(0, 99) < 100 - pw, 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
